// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle for alu_seq.
// The master drives start/Sel_OP/Rx/Ry. The slave returns R0/Flags/busy/done.
interface alu_seq_if #(
   parameter int WIDTH = 8
);
   // Handshake: start is sampled only while the ALU is idle.
   // While busy or done is high, start is dropped rather than queued.
   // done is a one-cycle pulse marking the cycle in which R0/Flags hold a new result.
   logic             start;
   logic [3:0]       Sel_OP;
   logic [WIDTH-1:0] Rx;
   logic [WIDTH-1:0] Ry;
   logic [WIDTH-1:0] R0;
   logic [3:0]       Flags;
   logic             busy;
   logic             done;

   modport master (
      output start, Sel_OP, Rx, Ry,
      input  R0, Flags, busy, done
   );

   modport slave (
      input  start, Sel_OP, Rx, Ry,
      output R0, Flags, busy, done
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a registered result and {V,N,C,Z} flags.
// Flags bit 0 is Z.
// Single-cycle ops finish on the start edge.
// Shifts, rotates and MUL iterate one bit per cycle in ITER.
// Optional feature: define ALU_SEQ_MUL_EN to build the shift-add multiplier (opcode 10).
// Without it, opcode 10 behaves as a reserved opcode.
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   alu_seq_if.slave bus,
   output logic     dbg_state_o
);
   localparam int               CW    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
   localparam logic [CW-1:0]    W_CNT = CW'(WIDTH);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_SHL = 4'd2;
   localparam logic [3:0] OP_SHR = 4'd3;
   localparam logic [3:0] OP_NOT = 4'd4;
   localparam logic [3:0] OP_AND = 4'd5;
   localparam logic [3:0] OP_OR  = 4'd6;
   localparam logic [3:0] OP_XOR = 4'd7;
   localparam logic [3:0] OP_ADC = 4'd8;
   localparam logic [3:0] OP_SBB = 4'd9;
   localparam logic [3:0] OP_ROL = 4'd11;
   localparam logic [3:0] OP_ROR = 4'd12;
   localparam logic [3:0] OP_CMP = 4'd13;
`ifdef ALU_SEQ_MUL_EN
   localparam logic [3:0] OP_MUL = 4'd10;
`endif

   typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] r0_q, r0_d;
   logic [3:0]       flags_q, flags_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             done_q, done_d;
`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
   logic [WIDTH:0]     mul_sum;
`endif

   logic             add_cin, sub_cin, v_add, v_sub, step_c;
   logic [WIDTH:0]   sum_w, dif_w;
   logic [WIDTH-1:0] step_val;
   logic [CW-1:0]    n_shift, n_rot;

   function automatic logic [3:0] mk_flags(input logic v, input logic [WIDTH-1:0] r,
                                           input logic c);
      return {v, r[WIDTH-1], c, ~|r};
   endfunction

   // The single-cycle datapath works directly on the live inputs.
   // Its result is captured on the start edge.
   assign add_cin = (bus.Sel_OP == OP_ADC) ? flags_q[1] : 1'b0;
   assign sub_cin = (bus.Sel_OP == OP_SBB) ? flags_q[1] : 1'b0;
   assign sum_w   = {1'b0, bus.Rx} + {1'b0, bus.Ry} + {{WIDTH{1'b0}}, add_cin};
   assign dif_w   = {1'b0, bus.Rx} - {1'b0, bus.Ry} - {{WIDTH{1'b0}}, sub_cin};
   assign v_add   = (bus.Rx[WIDTH-1] == bus.Ry[WIDTH-1]) && (sum_w[WIDTH-1] != bus.Rx[WIDTH-1]);
   assign v_sub   = (bus.Rx[WIDTH-1] != bus.Ry[WIDTH-1]) && (dif_w[WIDTH-1] != bus.Rx[WIDTH-1]);
   // Shift counts saturate at WIDTH. Rotate counts wrap modulo WIDTH.
   assign n_shift = (bus.Ry >= W_VAL) ? W_CNT : CW'(bus.Ry);
   assign n_rot   = CW'(bus.Ry % W_VAL);

   // One-bit step of the latched shift/rotate operand; step_c is the bit moved out.
   always_comb begin
      step_val = a_q;
      step_c   = 1'b0;
      case (op_q)
         OP_SHL: begin step_val = {a_q[WIDTH-2:0], 1'b0};      step_c = a_q[WIDTH-1]; end
         OP_SHR: begin step_val = {1'b0, a_q[WIDTH-1:1]};      step_c = a_q[0];       end
         OP_ROL: begin step_val = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; step_c = a_q[WIDTH-1]; end
         OP_ROR: begin step_val = {a_q[0], a_q[WIDTH-1:1]};    step_c = a_q[0];       end
         default: ;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // Shift-add multiplier step.
   // The high half accumulates the multiplicand when the low bit is set, then the pair shifts right.
   always_comb begin
      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      prod_step = {mul_sum, prod_q[WIDTH-1:1]};
   end
`endif

   // Next-state and datapath: accept requests in IDLE, step once per cycle in ITER.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      r0_d    = r0_q;
      flags_d = flags_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      prod_d  = prod_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.start && !done_q) begin
               op_d   = bus.Sel_OP;
               a_d    = bus.Rx;
               done_d = 1'b1;
               case (bus.Sel_OP)
                  OP_ADD, OP_ADC: begin
                     r0_d    = sum_w[WIDTH-1:0];
                     flags_d = mk_flags(v_add, sum_w[WIDTH-1:0], sum_w[WIDTH]);
                  end
                  OP_SUB, OP_SBB: begin
                     r0_d    = dif_w[WIDTH-1:0];
                     flags_d = mk_flags(v_sub, dif_w[WIDTH-1:0], dif_w[WIDTH]);
                  end
                  OP_CMP: flags_d = mk_flags(v_sub, dif_w[WIDTH-1:0], dif_w[WIDTH]);
                  OP_NOT: begin r0_d = ~bus.Rx;          flags_d = mk_flags(1'b0, ~bus.Rx, 1'b0);          end
                  OP_AND: begin r0_d = bus.Rx & bus.Ry;  flags_d = mk_flags(1'b0, bus.Rx & bus.Ry, 1'b0);  end
                  OP_OR:  begin r0_d = bus.Rx | bus.Ry;  flags_d = mk_flags(1'b0, bus.Rx | bus.Ry, 1'b0);  end
                  OP_XOR: begin r0_d = bus.Rx ^ bus.Ry;  flags_d = mk_flags(1'b0, bus.Rx ^ bus.Ry, 1'b0);  end
                  OP_SHL, OP_SHR: begin
                     if (n_shift == '0) begin
                        r0_d    = bus.Rx;
                        flags_d = mk_flags(1'b0, bus.Rx, 1'b0);
                     end else begin
                        state_d = ITER;
                        cnt_d   = n_shift;
                        done_d  = 1'b0;
                     end
                  end
                  OP_ROL, OP_ROR: begin
                     if (n_rot == '0) begin
                        r0_d    = bus.Rx;
                        flags_d = mk_flags(1'b0, bus.Rx, 1'b0);
                     end else begin
                        state_d = ITER;
                        cnt_d   = n_rot;
                        done_d  = 1'b0;
                     end
                  end
`ifdef ALU_SEQ_MUL_EN
                  OP_MUL: begin
                     state_d = ITER;
                     cnt_d   = W_CNT;
                     prod_d  = {{WIDTH{1'b0}}, bus.Ry};
                     done_d  = 1'b0;
                  end
`endif
                  // Reserved opcodes only pulse done.
                  default: ;
               endcase
            end
         end
         ITER: begin
            cnt_d = cnt_q - 1'b1;
            a_d   = step_val;
`ifdef ALU_SEQ_MUL_EN
            prod_d = prod_step;
`endif
            if (cnt_q == CW'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               r0_d    = step_val;
               flags_d = mk_flags(1'b0, step_val, step_c);
`ifdef ALU_SEQ_MUL_EN
               if (op_q == OP_MUL) begin
                  r0_d    = prod_step[WIDTH-1:0];
                  flags_d = mk_flags(1'b0, prod_step[WIDTH-1:0], |prod_step[2*WIDTH-1:WIDTH]);
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   // Asynchronous reset aborts any operation in flight without a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         r0_q    <= '0;
         flags_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         prod_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         r0_q    <= r0_d;
         flags_q <= flags_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
`ifdef ALU_SEQ_MUL_EN
         prod_q  <= prod_d;
`endif
      end
   end

   assign bus.R0      = r0_q;
   assign bus.Flags   = flags_q;
   assign bus.busy    = (state_q == ITER);
   assign bus.done    = done_q;
   assign dbg_state_o = (state_q == ITER);
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=8).
// Expected results are hand-computed.
// The MUL expectation follows ALU_SEQ_MUL_EN.
module tb_alu_seq;
   logic clk = 1'b0;
   logic rst_n;
   logic dbg_state;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [7:0] mr;
   logic [3:0] mf;
   bit         saw_done;

   alu_seq_if #(.WIDTH(8)) bus();

   alu_seq #(.WIDTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request, scramble the inputs afterwards, then wait (bounded) for done.
   // Check busy length, result and the single-cycle done pulse.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] x,
                         input logic [7:0] y, input logic [7:0] er, input logic [3:0] ef,
                         input int eb);
      int guard;
      int busy_n;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.Sel_OP = op;
      bus.Rx     = x;
      bus.Ry     = y;
      @(negedge clk);
      bus.start  = 1'b0;
      bus.Sel_OP = 4'($urandom_range(0, 15));
      bus.Rx     = 8'($urandom_range(0, 255));
      bus.Ry     = 8'($urandom_range(0, 255));
      guard  = 0;
      busy_n = 0;
      while (bus.done !== 1'b1 && guard < 64) begin
         if (bus.busy === 1'b1) busy_n++;
         guard++;
         @(negedge clk);
      end
      check({tag, " done"}, 32'(bus.done), 32'd1);
      check({tag, " busy_cycles"}, 32'(busy_n), 32'(eb));
      check({tag, " R0"}, 32'(bus.R0), 32'(er));
      check({tag, " Flags"}, 32'(bus.Flags), 32'(ef));
      check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
      @(negedge clk);
      check({tag, " done_pulse_len"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      bus.start  = 1'b0;
      bus.Sel_OP = 4'd0;
      bus.Rx     = 8'd0;
      bus.Ry     = 8'd0;
      rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      check("reset R0", 32'(bus.R0), 32'd0);
      check("reset Flags", 32'(bus.Flags), 32'd0);
      check("reset busy", 32'(bus.busy), 32'd0);
      check("reset done", 32'(bus.done), 32'd0);
      check("reset state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;

      //      tag            op     Rx     Ry     R0     VNCZ     busy
      run_op("add_wrap",   4'd0,  8'hFF, 8'h01, 8'h00, 4'b0011, 0);
      run_op("sub_ovf",    4'd1,  8'h80, 8'h01, 8'h7F, 4'b1000, 0);
      run_op("sub_borrow", 4'd1,  8'h00, 8'h01, 8'hFF, 4'b0110, 0);
      run_op("sbb",        4'd9,  8'h10, 8'h00, 8'h0F, 4'b0000, 0);
      run_op("add_setc",   4'd0,  8'hFF, 8'h01, 8'h00, 4'b0011, 0);
      run_op("adc",        4'd8,  8'h7F, 8'h00, 8'h80, 4'b1100, 0);
      run_op("and",        4'd5,  8'hF0, 8'h3C, 8'h30, 4'b0000, 0);
      run_op("or",         4'd6,  8'h0F, 8'h80, 8'h8F, 4'b0100, 0);
      run_op("xor",        4'd7,  8'hAA, 8'hAA, 8'h00, 4'b0001, 0);
      run_op("not",        4'd4,  8'h0F, 8'h55, 8'hF0, 4'b0100, 0);
      run_op("cmp",        4'd13, 8'h05, 8'h07, 8'hF0, 4'b0110, 0);
      run_op("shl3",       4'd2,  8'h81, 8'h03, 8'h08, 4'b0000, 3);
      run_op("shr9",       4'd3,  8'h81, 8'h09, 8'h00, 4'b0011, 8);
      run_op("shl0",       4'd2,  8'h5A, 8'h00, 8'h5A, 4'b0000, 0);
      run_op("ror9",       4'd12, 8'h01, 8'h09, 8'h80, 4'b0110, 1);
`ifdef ALU_SEQ_MUL_EN
      mr = 8'h10; mf = 4'b0010;
      run_op("mul",        4'd10, 8'h10, 8'h11, mr,    mf,      8);
`else
      mr = 8'h80; mf = 4'b0110;
      run_op("mul_rsvd",   4'd10, 8'h10, 8'h11, mr,    mf,      0);
`endif
      run_op("rsvd14",     4'd14, 8'h33, 8'h44, mr,    mf,      0);

      // ROL by 1, with start held through the busy cycle and the done cycle.
      @(negedge clk);
      bus.start = 1'b1; bus.Sel_OP = 4'd11; bus.Rx = 8'h81; bus.Ry = 8'h01;
      @(negedge clk);
      check("rol busy", 32'(bus.busy), 32'd1);
      bus.Sel_OP = 4'd0; bus.Rx = 8'h01; bus.Ry = 8'h01;
      @(negedge clk);
      check("rol done", 32'(bus.done), 32'd1);
      check("rol R0", 32'(bus.R0), 32'h03);
      check("rol Flags", 32'(bus.Flags), 32'b0010);
      @(negedge clk);
      bus.start = 1'b0;
      check("ignored start done", 32'(bus.done), 32'd0);
      check("ignored start R0", 32'(bus.R0), 32'h03);
      @(negedge clk);
      check("no queued op R0", 32'(bus.R0), 32'h03);
      check("no queued op done", 32'(bus.done), 32'd0);

      // Second ROL, aborted by reset while iterating.
      @(negedge clk);
      bus.start = 1'b1; bus.Sel_OP = 4'd11; bus.Rx = 8'h81; bus.Ry = 8'h05;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("rol2 busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort R0", 32'(bus.R0), 32'd0);
      check("abort Flags", 32'(bus.Flags), 32'd0);
      check("abort busy", 32'(bus.busy), 32'd0);
      check("abort done", 32'(bus.done), 32'd0);
      check("abort state", 32'(dbg_state), 32'd0);
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (bus.done === 1'b1) saw_done = 1'b1;
      end
      check("abort no done", 32'(saw_done), 32'd0);
      run_op("add_after_rst", 4'd0, 8'h02, 8'h03, 8'h05, 4'b0000, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits; legal range 4..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port Sel_OP  input  4  operation code.
REQ-006 SHALL have port Rx  input  WIDTH  operand A.
REQ-007 SHALL have port Ry  input  WIDTH  operand B, or shift/rotate count.
REQ-008 SHALL have port R0  output  WIDTH  registered result.
REQ-009 SHALL have port Flags  output  4  registered {V,N,C,Z}, bit0=Z.
REQ-010 SHALL have port busy  output  1  high while a multi-cycle operation iterates.
REQ-011 SHALL have port done  output  1  one-cycle pulse when R0/Flags update.

Function
REQ-012 SHALL decode opcodes: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 NOT Rx, 5 AND, 6 OR, 7 XOR, 8 ADC, 9 SBB, 10 MUL, 11 ROL, 12 ROR, 13 CMP; 14-15 reserved.
REQ-013 SHALL latch Sel_OP, Rx, Ry on the clk edge where start=1 in IDLE; later input changes have no effect on that operation.
REQ-014 SHALL use states IDLE, ITER: single-cycle ops (0,1,4-9,13, reserved) stay in IDLE; SHL/SHR/ROL/ROR with step count n>=1 and MUL go to ITER.
REQ-015 Single-cycle ops SHALL update R0/Flags on the start edge, with done=1 for the following cycle (latency 1).
REQ-016 Shifts SHALL perform n=min(Ry,WIDTH) one-bit steps; rotates n=Ry mod WIDTH steps; n=0 behaves as a single-cycle op returning Rx, C=0.
REQ-017 In ITER, busy SHALL be 1; one step per cycle; after the last step R0/Flags update and done pulses; latency = n cycles for shifts/rotates, WIDTH cycles for MUL.
REQ-018 start asserted while busy=1 or done=1 SHALL be ignored, not queued.
REQ-019 ADD/ADC/SUB/SBB SHALL be modulo 2^WIDTH; ADC adds stored C; SBB subtracts stored C.
REQ-020 MUL SHALL be unsigned shift-add; R0 = low WIDTH bits of product; C=1 iff high half nonzero.
REQ-021 Z SHALL be 1 iff the WIDTH-bit result is zero; N = result MSB.
REQ-022 C SHALL be: carry-out (add), borrow i.e. 1 when unsigned minuend < subtrahend(+C) (sub/CMP), last bit shifted/rotated out (shift/rotate), 0 for logic ops.
REQ-023 V SHALL be signed two's-complement overflow for ADD/ADC/SUB/SBB/CMP, else 0.
REQ-024 CMP SHALL update Flags as SUB but leave R0 unchanged.
REQ-025 Reserved opcodes SHALL leave R0 and Flags unchanged and still pulse done.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, R0=0, Flags=0, busy=0, done=0, iteration counter cleared.
REQ-027 Reset during ITER SHALL abort the operation with no done pulse; first start after release is accepted normally.

Configuration
REQ-028 Macro ALU_SEQ_MUL_EN defined SHALL compile in the MUL datapath per REQ-020.
REQ-029 Without ALU_SEQ_MUL_EN, opcode 10 SHALL behave as reserved (REQ-025) and no multiplier logic SHALL be synthesised.

Verification
REQ-030 WIDTH=8, ADD Rx=0xFF Ry=0x01 -> next cycle R0=0x00, Flags Z=1 C=1 N=0 V=0, done one cycle.
REQ-031 WIDTH=8, SUB 0x80-0x01 -> R0=0x7F, V=1 C=0 N=0; then SBB 0x10-0x00 with C=1 preset by SUB 0x00-0x01 -> R0=0x0F.
REQ-032 WIDTH=8, SHL Rx=0x81 Ry=3 -> busy 3 cycles, R0=0x08, C=0; SHR Ry=9 -> latency 8, R0=0x00, Z=1, C=1.
REQ-033 WIDTH=8 with ALU_SEQ_MUL_EN, MUL 0x10*0x11 -> done after 8 cycles, R0=0x10, C=1; without macro -> R0/Flags unchanged, done after 1 cycle.
REQ-034 ROL Rx=0x81 Ry=1, pulse start again mid-operation and drop rst_n during a second ROL -> R0=0x03 C=1, extra start ignored, reset clears all outputs with no done.
